// File: rtl/se_channel_scale.sv
// se_channel_scale: per-channel excitation scaling of a feature stream (Q8.8), ready/valid output.
// Optional SE_SCALE_CLAMP_EN clamps weights to [0,1.0] and saturates results instead of wrapping.
module se_channel_scale #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int NUM_CHANNELS = 16,
  parameter int SPATIAL_SIZE = 49
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] scale_in,
  input  logic                  scale_valid,
  input  logic [DATA_WIDTH-1:0] feat_in,
  input  logic                  feat_valid,
  output logic                  feat_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  scale_err
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int PW = SPATIAL_SIZE > 1 ? $clog2(SPATIAL_SIZE) : 1;
  localparam logic signed [2*DW-1:0] HALF = (2*DW)'(1) << (FRAC_BITS - 1);

  typedef enum logic {LOAD, SCALE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [PW-1:0]          pix_q, pix_d;
  logic [DW-1:0]          out_q, out_d, w_in, res;
  logic                   ov_q, ov_d, done_q, done_d, err_q, err_d;
  logic [DW-1:0]          w_q [NUM_CHANNELS];
  logic signed [2*DW-1:0] prod, rnd;
  logic                   in_scale, accept, last_ch, last_pix;

  assign in_scale   = state_q == SCALE;
  assign feat_ready = in_scale && (!ov_q || out_ready);
  assign accept     = feat_ready && feat_valid;
  assign last_ch    = ch_q == CW'(NUM_CHANNELS - 1);
  assign last_pix   = pix_q == PW'(SPATIAL_SIZE - 1);
  assign prod       = (2*DW)'($signed(feat_in)) * (2*DW)'($signed(w_q[ch_q]));
  assign rnd        = (prod + HALF) >>> FRAC_BITS;

`ifdef SE_SCALE_CLAMP_EN
  localparam logic signed [DW-1:0]   ONE  = DW'(1) << FRAC_BITS;
  localparam logic signed [2*DW-1:0] MAXV = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] MINV = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  assign w_in = $signed(scale_in) < 0 ? '0 : $signed(scale_in) > ONE ? ONE : scale_in;
  assign res  = rnd > MAXV ? MAXV[DW-1:0] : rnd < MINV ? MINV[DW-1:0] : rnd[DW-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^rnd[2*DW-1:DW];
  assign w_in      = scale_in;
  assign res       = rnd[DW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    if (!in_scale && scale_valid) begin
      ch_d    = last_ch ? '0 : ch_q + 1'b1;
      state_d = last_ch ? SCALE : LOAD;
    end
    if (accept) begin
      ch_d    = last_ch ? '0 : ch_q + 1'b1;
      pix_d   = !last_ch ? pix_q : last_pix ? '0 : pix_q + 1'b1;
      state_d = last_ch && last_pix ? LOAD : SCALE;
    end
    done_d = accept && last_ch && last_pix;
    err_d  = err_q || (in_scale && scale_valid);
    out_d  = accept ? res : out_q;
    ov_d   = accept || (ov_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      ch_q    <= '0;
      pix_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Weights are only written in LOAD, so the set in use stays intact for the whole frame.
  always_ff @(posedge clk) begin
    if (!in_scale && scale_valid) w_q[ch_q] <= w_in;
  end

  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign busy      = in_scale;
  assign done      = done_q;
  assign scale_err = err_q;
endmodule

// File: tb/tb_se_channel_scale.sv
// tb_se_channel_scale: directed checks of se_channel_scale with 4 channels x 2 pixels.
module tb_se_channel_scale;
  typedef logic signed [15:0] vec8_t [8];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] scale_in = '0;
  logic        scale_valid = 1'b0;
  logic [15:0] feat_in = '0;
  logic        feat_valid = 1'b0;
  logic        feat_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, scale_err;
  int          checks = 0;
  int          passed = 0;

  se_channel_scale #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_CHANNELS(4), .SPATIAL_SIZE(2)
  ) dut (
    .clk(clk), .rst(rst),
    .scale_in(scale_in), .scale_valid(scale_valid),
    .feat_in(feat_in), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .scale_err(scale_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic signed [15:0] w0, w1, w2, w3);
    logic signed [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      scale_valid = 1'b1;
      scale_in = w[i];
      step();
      chk("busy_load", busy, i == 3);
    end
    scale_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic signed [15:0] f, input logic signed [15:0] e);
    feat_valid = 1'b1;
    feat_in = f;
    step();
    chk(tag, $signed(out_data), e);
    chk("out_valid", out_valid, 1);
  endtask

  task automatic frame(input string tag, input int first, input vec8_t f, input vec8_t e);
    for (int i = first; i < 8; i++) begin
      send(tag, f[i], e[i]);
      chk("done", done, i == 7);
    end
    chk("busy_end", busy, 0);
    feat_valid = 1'b0;
    step();
    chk("done_once", done, 0);
  endtask

  initial begin
    vec8_t k1000, base;
    logic signed [15:0] big;
    k1000 = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    base  = '{1000, 500, 0, 250, 1000, 500, 0, 250};
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_feat_ready", feat_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_scale_err", scale_err, 0);
    step();
    rst = 1'b1;
    step();

    // 1: basic frame
    load_w(256, 128, 0, 64);
    chk("feat_ready_scale", feat_ready, 1);
    frame("t1", 0, k1000, base);

    // 2: rounding
    load_w(128, 128, 128, 128);
    frame("t2", 0, '{3, -3, 1, 5, 1000, 1000, 1000, 1000}, '{2, -1, 1, 3, 500, 500, 500, 500});

    // 3: back-pressure
    load_w(256, 128, 0, 64);
    send("t3_first", 1000, 1000);
    out_ready = 1'b0;
    #1;
    chk("t3_stall_ready", feat_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_data", $signed(out_data), 1000);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_ready", feat_ready, 0);
    end
    out_ready = 1'b1;
    frame("t3", 1, k1000, base);

    // 4: overflow handling
    load_w(512, 256, 256, 256);
`ifdef SE_SCALE_CLAMP_EN
    big = 20000;
`else
    big = -25536;
`endif
    frame("t4", 0, '{20000, 0, 0, 0, 0, 0, 0, 0}, '{big, 0, 0, 0, 0, 0, 0, 0});

    // 5: stray scale_valid in SCALE
    load_w(256, 128, 0, 64);
    chk("t5_err_clear", scale_err, 0);
    send("t5_first", 1000, 1000);
    feat_valid = 1'b0;
    scale_valid = 1'b1;
    scale_in = 16'sd999;
    step();
    scale_valid = 1'b0;
    chk("t5_err_set", scale_err, 1);
    frame("t5", 1, k1000, base);
    chk("t5_err_sticky", scale_err, 1);

    // 6: reset mid-frame
    load_w(256, 128, 0, 64);
    for (int i = 0; i < 3; i++) send("t6_pre", 1000, base[i]);
    rst = 1'b0;
    #1;
    chk("t6_out_data", out_data, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", scale_err, 0);
    chk("t6_ready", feat_ready, 0);
    feat_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    load_w(64, 0, 128, 256);
    frame("t6", 0, k1000, '{250, 0, 500, 1000, 250, 0, 500, 1000});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/se_channel_scale.md
Name: se_channel_scale

Overview:
- Final stage of the SE layer; sits directly downstream of the hard-sigmoid stage.
- Captures one hard-sigmoid excitation weight per channel (Q8.8), then streams the block's feature map through.
- Each element is multiplied by its channel's weight, rounded, and emitted on a ready/valid stream toward the next MobileNetV3 layer.

Parameters:
- DATA_WIDTH, 16, width of features, weights and outputs (signed, Q8.8)
- FRAC_BITS, 8, fractional bits of the weight
- NUM_CHANNELS, 16, channels per SE block (>=2)
- SPATIAL_SIZE, 49, pixels per channel per frame (>=1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset; asserted when 0, released synchronously to clk
- scale_in  input  DATA_WIDTH  excitation weight, channel order 0..NUM_CHANNELS-1
- scale_valid  input  1  scale_in qualifier; no back-pressure is possible
- feat_in  input  DATA_WIDTH  feature element; pixel-major, channel innermost
- feat_valid  input  1  feature qualifier
- feat_ready  output  1  feature accepted when feat_valid&&feat_ready
- out_data  output  DATA_WIDTH  scaled feature
- out_valid  output  1  out_data qualifier
- out_ready  input  1  downstream accept
- busy  output  1  high in SCALE state
- done  output  1  one-cycle pulse after last element of a frame accepted
- scale_err  output  1  sticky: scale_valid seen outside LOAD

Behaviour:
- Reset (rst=0): FSM=LOAD; ch_cnt, pix_cnt=0; out_valid, done, busy, scale_err=0; out_data=0; feat_ready=0. Weight buffer contents are don't-care. Reset mid-frame aborts the frame; no partial output survives.
- LOAD state:
  - feat_ready=0.
  - Each scale_valid cycle writes weight[ch_cnt] and increments ch_cnt.
  - On the write with ch_cnt==NUM_CHANNELS-1: ch_cnt->0, FSM->SCALE next cycle.
- SCALE state:
  - busy=1; scale_valid here is dropped and sets scale_err (cleared only by reset).
  - feat_ready = !out_valid || out_ready (1-deep output register, no combinational path from feat_valid).
  - On accept: prod = feat_in * weight[ch_cnt], signed 2*DATA_WIDTH. Result = (prod + (1<<(FRAC_BITS-1))) >>> FRAC_BITS, narrowed to DATA_WIDTH per optional feature.
  - Result is registered; out_valid=1 the next cycle (latency 1).
  - ch_cnt increments, wrapping at NUM_CHANNELS-1, at which point pix_cnt increments.
  - On accept with ch_cnt==NUM_CHANNELS-1 and pix_cnt==SPATIAL_SIZE-1: counters->0, done=1 next cycle, FSM->LOAD.
- Output register: holds out_data/out_valid stable while out_valid&&!out_ready. It clears out_valid on out_ready when no new accept occurs in that cycle. Simultaneous output handshake and new accept loads the new value with out_valid staying 1.
- Overlap: the pending last output may drain while the next frame's weights load in LOAD; weights in use are never overwritten mid-frame.
- feat_valid may drop between elements; counters only advance on handshake.

Optional Feature:
- Macro SE_SCALE_CLAMP_EN.
- Defined:
  - Weights are clamped on write to [0, 1<<FRAC_BITS].
  - Rounded result is saturated to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1].
- Undefined:
  - Weights are stored raw.
  - Result is truncated to low DATA_WIDTH bits (two's-complement wrap).

Test Plan (NUM_CHANNELS=4, SPATIAL_SIZE=2):
1. Load weights 256,128,0,64; stream feat 1000 x8 with out_ready=1 -> outputs 1000,500,0,250,1000,500,0,250. done pulses once, 1 cycle after the 8th accept. busy falls and LOAD is re-entered.
2. Rounding: weight[0]=128; feat 3 -> out 2; feat -3 -> out -1; feat 1 -> out 1.
3. Back-pressure: hold out_ready=0 after first output -> out_data stable, feat_ready=0, counters frozen. Release -> remaining outputs in order, none lost or duplicated.
4. Weight 512 on ch0, feat 20000 -> with SE_SCALE_CLAMP_EN: 20000; without: -25536.
5. Pulse scale_valid during SCALE -> scale_err=1 and stays set; current frame outputs unchanged; weights unchanged.
6. Assert rst=0 after 3 of 8 elements -> outputs zero and out_valid=0 immediately. After release the FSM is in LOAD; a full new frame produces correct results.
